// File: rtl/powlib_cntr_pkg.sv
// Shared constants and helpers for the powlib counter family.
// Direction and mode encodings plus the range-size helper.
package powlib_cntr_pkg;

  localparam logic CNTR_UP = 1'b0;
  localparam logic CNTR_DN = 1'b1;

  localparam int unsigned CNTR_WRAP = 0;
  localparam int unsigned CNTR_SAT  = 1;

  // Number of distinct values in [min, max]; wide enough for a full 32-bit range.
  function automatic longint unsigned rng(longint unsigned min, longint unsigned max);
    return max - min + 1;
  endfunction

endpackage

// File: rtl/powlib_bcntr_step.sv
// Combinational next-value and terminal-count calculator for a bounded counter.
// Shared by the single counter and the planned multi-channel counter array.
module powlib_bcntr_step
  import powlib_cntr_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned MIN = 0,
  parameter int unsigned MAX = 2**W-1,
  parameter int unsigned SAT = CNTR_WRAP
) (
  input  logic [W-1:0] cntr,
  input  logic [W:0]   s,
  input  logic         dn,
  output logic [W-1:0] nxt,
  output logic         hit
);

  localparam int unsigned WP = W + 1;
  localparam logic [W:0] MIN_X = WP'(MIN);
  localparam logic [W:0] MAX_X = WP'(MAX);
  localparam logic [W:0] RNG_X = WP'(rng(MIN, MAX));

  logic [W:0] c_x;
  logic [W:0] h;
  logic [W:0] sum;
  logic       unused_msb;

  // W+1 bit arithmetic: cntr+s and cntr+rng never exceed 2**(W+1)-1.
  always_comb begin
    c_x = {1'b0, cntr};
    h   = '0;
    sum = c_x;
    hit = 1'b0;
    if (s == '0) begin
      sum = c_x;
    end else if (dn == CNTR_UP) begin
      h = MAX_X - c_x;
      if (s < h) begin
        sum = c_x + s;
      end else if (s == h || SAT == CNTR_SAT) begin
        sum = MAX_X;
        hit = 1'b1;
      end else begin
        sum = c_x + s - RNG_X;
        hit = 1'b1;
      end
    end else begin
      h = c_x - MIN_X;
      if (s < h) begin
        sum = c_x - s;
      end else if (s == h || SAT == CNTR_SAT) begin
        sum = MIN_X;
        hit = 1'b1;
      end else begin
        sum = c_x + RNG_X - s;
        hit = 1'b1;
      end
    end
  end

  assign nxt        = sum[W-1:0];
  assign unused_msb = sum[W];

endmodule

// File: rtl/powlib_bcntr.sv
// Bounded up/down counter with wrap/saturate, load clamp, registered tc pulse
// and bound flags. Priority is clr > ld > adv.
module powlib_bcntr
  import powlib_cntr_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned X    = 1,
  parameter int unsigned MIN  = 0,
  parameter int unsigned MAX  = 2**W-1,
  parameter int unsigned INIT = 0,
  parameter int unsigned SAT  = CNTR_WRAP,
  parameter int unsigned ELD  = 1,
  parameter int unsigned EDX  = 0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cntr,
  input  logic [W-1:0] nval,
  input  logic         adv,
  input  logic         dn,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] dx,
  output logic         tc,
  output logic         atmax,
  output logic         atmin
);

  if (MIN > MAX || INIT < MIN || INIT > MAX) begin : g_param_check
    $fatal(1, "powlib_bcntr: parameters must satisfy MIN <= INIT <= MAX");
  end

  localparam int unsigned WP = W + 1;
  localparam logic [W-1:0] MIN_W  = W'(MIN);
  localparam logic [W-1:0] MAX_W  = W'(MAX);
  localparam logic [W-1:0] INIT_W = W'(INIT);
  localparam logic [W:0]   RNG_X  = WP'(rng(MIN, MAX));
  localparam logic [W:0]   X_X    = WP'(X);

  logic [W-1:0] cntr_q, cntr_d;
  logic         tc_q, tc_d;
  logic [W:0]   step;
  logic         ld_en;
  logic [W-1:0] nval_c;
  logic [W-1:0] nxt;
  logic         hit;
  logic         unused_ins;

  assign step  = (EDX != 0) ? {1'b0, dx} : X_X;
  assign ld_en = (ELD != 0) && ld;

  always_comb begin
    nval_c = nval;
    if (nval < MIN_W) begin
      nval_c = MIN_W;
    end else if (nval > MAX_W) begin
      nval_c = MAX_W;
    end
  end

  powlib_bcntr_step #(
    .W  (W),
    .MIN(MIN),
    .MAX(MAX),
    .SAT(SAT)
  ) u_step (
    .cntr(cntr_q),
    .s   (step),
    .dn  (dn),
    .nxt (nxt),
    .hit (hit)
  );

  always_comb begin
    cntr_d = cntr_q;
    tc_d   = 1'b0;
    if (clr) begin
      cntr_d = INIT_W;
    end else if (ld_en) begin
      cntr_d = nval_c;
    end else if (adv) begin
      cntr_d = nxt;
      tc_d   = hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntr_q <= INIT_W;
      tc_q   <= 1'b0;
    end else begin
      cntr_q <= cntr_d;
      tc_q   <= tc_d;
    end
  end

  // A step wider than the range has no defined result.
  always_ff @(posedge clk) begin
    if (!rst && adv && !clr && !ld_en) begin
      assert (step <= RNG_X)
      else $error("powlib_bcntr: step %0d exceeds range %0d", step, RNG_X);
    end
  end

  assign cntr       = cntr_q;
  assign tc         = tc_q;
  assign atmax      = (cntr_q == MAX_W);
  assign atmin      = (cntr_q == MIN_W);
  assign unused_ins = ^{dx, nval, ld};

endmodule

// File: tb/tb_powlib_bcntr.sv
// Self-checking bench: three counter configurations against an arithmetic model.
module tb_powlib_bcntr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] nval_v  [3];
  logic [7:0] dx_v    [3];
  logic [7:0] cntr_v  [3];
  logic       adv_v   [3];
  logic       dn_v    [3];
  logic       ld_v    [3];
  logic       clr_v   [3];
  logic       tc_v    [3];
  logic       atmax_v [3];
  logic       atmin_v [3];

  int p_min  [3] = '{3, 3, 0};
  int p_max  [3] = '{10, 10, 255};
  int p_init [3] = '{5, 5, 0};
  int p_sat  [3] = '{0, 1, 0};
  int p_edx  [3] = '{1, 1, 0};

  int m_cnt [3];
  bit m_tc  [3];
  int nchk = 0;
  int nerr = 0;

  powlib_bcntr #(.W(8), .X(1), .MIN(3), .MAX(10), .INIT(5), .SAT(0), .ELD(1), .EDX(1)) u_a (
    .clk(clk), .rst(rst), .cntr(cntr_v[0]), .nval(nval_v[0]), .adv(adv_v[0]), .dn(dn_v[0]),
    .ld(ld_v[0]), .clr(clr_v[0]), .dx(dx_v[0]), .tc(tc_v[0]), .atmax(atmax_v[0]),
    .atmin(atmin_v[0])
  );

  powlib_bcntr #(.W(8), .X(1), .MIN(3), .MAX(10), .INIT(5), .SAT(1), .ELD(1), .EDX(1)) u_b (
    .clk(clk), .rst(rst), .cntr(cntr_v[1]), .nval(nval_v[1]), .adv(adv_v[1]), .dn(dn_v[1]),
    .ld(ld_v[1]), .clr(clr_v[1]), .dx(dx_v[1]), .tc(tc_v[1]), .atmax(atmax_v[1]),
    .atmin(atmin_v[1])
  );

  powlib_bcntr #(.W(8), .X(1), .MIN(0), .MAX(255), .INIT(0), .SAT(0), .ELD(1), .EDX(0)) u_c (
    .clk(clk), .rst(rst), .cntr(cntr_v[2]), .nval(nval_v[2]), .adv(adv_v[2]), .dn(dn_v[2]),
    .ld(ld_v[2]), .clr(clr_v[2]), .dx(dx_v[2]), .tc(tc_v[2]), .atmax(atmax_v[2]),
    .atmin(atmin_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    for (int j = 0; j < 3; j++) begin
      nval_v[j] = '0;
      dx_v[j]   = '0;
      adv_v[j]  = 1'b0;
      dn_v[j]   = 1'b0;
      ld_v[j]   = 1'b0;
      clr_v[j]  = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      m_cnt[j] = p_init[j];
      m_tc[j]  = 1'b0;
    end
  endtask

  // Range arithmetic straight from the bound rules, on plain signed ints.
  task automatic model(input int k, input bit c, input bit l, input bit a, input bit d,
                       input int nv, input int dxv);
    int s, t, lo, hi, span;
    for (int j = 0; j < 3; j++) begin
      if (j != k) m_tc[j] = 1'b0;
    end
    lo   = p_min[k];
    hi   = p_max[k];
    span = hi - lo + 1;
    if (c) begin
      m_cnt[k] = p_init[k];
      m_tc[k]  = 1'b0;
    end else if (l) begin
      m_cnt[k] = (nv < lo) ? lo : (nv > hi) ? hi : nv;
      m_tc[k]  = 1'b0;
    end else if (a) begin
      s = (p_edx[k] != 0) ? dxv : 1;
      if (s == 0) begin
        m_tc[k] = 1'b0;
      end else if (!d) begin
        t        = m_cnt[k] + s;
        m_tc[k]  = (t >= hi);
        m_cnt[k] = (t <= hi) ? t : (p_sat[k] != 0) ? hi : t - span;
      end else begin
        t        = m_cnt[k] - s;
        m_tc[k]  = (t <= lo);
        m_cnt[k] = (t >= lo) ? t : (p_sat[k] != 0) ? lo : t + span;
      end
    end else begin
      m_tc[k] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s[%0d].cntr", tag, j), 32'(cntr_v[j]), 32'(m_cnt[j]));
      chk($sformatf("%s[%0d].tc", tag, j), 32'(tc_v[j]), 32'(m_tc[j]));
      chk($sformatf("%s[%0d].atmax", tag, j), 32'(atmax_v[j]), 32'(m_cnt[j] == p_max[j]));
      chk($sformatf("%s[%0d].atmin", tag, j), 32'(atmin_v[j]), 32'(m_cnt[j] == p_min[j]));
    end
  endtask

  task automatic cmd(input string tag, input int k, input bit c, input bit l, input bit a,
                     input bit d, input int nv, input int dxv);
    nval_v[k] = nv[7:0];
    dx_v[k]   = dxv[7:0];
    clr_v[k]  = c;
    ld_v[k]   = l;
    adv_v[k]  = a;
    dn_v[k]   = d;
    @(posedge clk);
    #1;
    idle_all();
    model(k, c, l, a, d, nv, dxv);
    check_all(tag);
  endtask

  initial begin
    int k, r, dxv;
    bit c, l, a, d;
    idle_all();
    rst = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Count to 9, then reset asynchronously between edges.
    repeat (4) cmd("pre_rst", 0, 0, 0, 1, 0, 0, 1);
    chk("pre_rst_9", 32'(cntr_v[0]), 32'd9);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;

    repeat (6) cmd("wrap_up", 0, 0, 0, 1, 0, 0, 1);
    chk("wrap_up_end", 32'(cntr_v[0]), 32'd3);
    cmd("ld4", 0, 0, 1, 0, 0, 4, 0);
    cmd("wrap_dn", 0, 0, 0, 1, 1, 0, 3);
    chk("wrap_dn_9", 32'(cntr_v[0]), 32'd9);
    cmd("step_dn", 0, 0, 0, 1, 1, 0, 3);
    cmd("prio", 0, 1, 1, 1, 0, 200, 1);
    chk("prio_5", 32'(cntr_v[0]), 32'd5);
    cmd("clamp_hi", 0, 0, 1, 0, 0, 200, 0);
    cmd("clamp_lo", 0, 0, 1, 0, 0, 0, 0);
    cmd("idle", 0, 0, 0, 0, 0, 0, 0);

    cmd("sat_ld8", 1, 0, 1, 0, 0, 8, 0);
    cmd("sat_up", 1, 0, 0, 1, 0, 0, 4);
    cmd("sat_hold", 1, 0, 0, 1, 0, 0, 4);
    chk("sat_hold_tc", 32'(tc_v[1]), 32'd1);
    cmd("sat_dn", 1, 0, 0, 1, 1, 0, 7);
    chk("sat_dn_min", 32'(atmin_v[1]), 32'd1);
    cmd("sat_zero", 1, 0, 0, 1, 1, 0, 0);

    cmd("full_ld", 2, 0, 1, 0, 0, 255, 0);
    cmd("full_up", 2, 0, 0, 1, 0, 0, 0);
    chk("full_up_0", 32'(cntr_v[2]), 32'd0);
    cmd("full_dn", 2, 0, 0, 1, 1, 0, 200);
    chk("full_dn_255", 32'(cntr_v[2]), 32'd255);

    repeat (400) begin
      k   = $urandom_range(0, 2);
      r   = $urandom_range(0, 99);
      c   = (r < 4);
      l   = (r >= 4 && r < 20);
      a   = (r >= 12);
      d   = 1'($urandom_range(0, 1));
      dxv = (k == 2) ? $urandom_range(0, 255) : $urandom_range(0, 8);
      cmd("rand", k, c, l, a, d, $urandom_range(0, 255), dxv);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
